nihilist_stream_decrypt: RTL and testbench

- Byte-serial decrypter that inverts the team's Polybius/Nihilist additive cipher.
- Consumes cipher bytes one per handshake, least-significant cipher byte first, which is message letter 0 first.
- Subtracts the repeating key's square position from each byte and maps the result back through the fixed 5x5 square.
- Emits plaintext bytes on a valid/ready stream towards the UART/display sink.

---
 rtl/nihilist_stream_decrypt_if.sv | 25 ++
 rtl/nihilist_stream_decrypt.sv | 143 ++++++++++++++
 tb/tb_nihilist_stream_decrypt.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nihilist_stream_decrypt_if.sv
// Cipher-in / plaintext-out stream bundle for the Nihilist decrypter.
// The slave modport is the decrypter's side; the master modport is its environment.
interface nihilist_stream_decrypt_if;
  localparam int unsigned DATA_W = 8;

  logic              i_w_valid;
  logic [DATA_W-1:0] i_w_data;
  logic              i_w_last;
  logic              o_r_ready;
  logic              o_r_valid;
  logic [DATA_W-1:0] o_r_data;
  logic              o_r_last;
  logic              o_r_key_err;
  logic              i_w_ready;

  modport slave (
    input  i_w_valid, i_w_data, i_w_last, i_w_ready,
    output o_r_ready, o_r_valid, o_r_data, o_r_last, o_r_key_err
  );

  modport master (
    output i_w_valid, i_w_data, i_w_last, i_w_ready,
    input  o_r_ready, o_r_valid, o_r_data, o_r_last, o_r_key_err
  );
endinterface

// File: rtl/nihilist_stream_decrypt.sv
// Byte-serial Nihilist decrypter: subtracts the repeating key's Polybius position
// from each cipher byte and maps the difference back through the fixed 5x5 square.
module nihilist_stream_decrypt #(
  parameter int unsigned p_secret_length = 6
) (
  input  logic                           i_w_clk,
  input  logic                           i_w_rst,
  input  logic                           i_w_start,
  input  logic [p_secret_length*8-1:0]   i_w_secret,
  nihilist_stream_decrypt_if.slave       strm_io,
  output logic [7:0]                     o_r_count
);
  localparam int unsigned KEY_W  = p_secret_length * 8;
  localparam int unsigned J_W    = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    secret_q, secret_d;
  logic [J_W-1:0]      j_q, j_d;
  logic [BYTE_W-1:0]   count_q, count_d;
  logic                valid_q, valid_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic                ready_c, accept_c, out_take_c;
  logic [BYTE_W-1:0]   key_c, pos_c, diff_c, char_c;

  // Square position of a key letter (case-folded); 0 for anything outside the square.
  function automatic logic [7:0] key_pos(input logic [7:0] ch);
    logic [7:0] u;
    u = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'd32 : ch;
    case (u)
      "D": key_pos = 8'd11;  "A": key_pos = 8'd12;  "N": key_pos = 8'd13;  "I": key_pos = 8'd14;  "E": key_pos = 8'd15;
      "L": key_pos = 8'd21;  "B": key_pos = 8'd22;  "C": key_pos = 8'd23;  "F": key_pos = 8'd24;  "G": key_pos = 8'd25;
      "H": key_pos = 8'd31;  "K": key_pos = 8'd32;  "M": key_pos = 8'd33;  "O": key_pos = 8'd34;  "P": key_pos = 8'd35;
      "Q": key_pos = 8'd41;  "R": key_pos = 8'd42;  "S": key_pos = 8'd43;  "T": key_pos = 8'd44;  "U": key_pos = 8'd45;
      "V": key_pos = 8'd51;  "W": key_pos = 8'd52;  "X": key_pos = 8'd53;  "Y": key_pos = 8'd54;  "Z": key_pos = 8'd55;
      default: key_pos = 8'd0;
    endcase
  endfunction

  // Letter at a square position; 0 means the difference is not a valid position.
  function automatic logic [7:0] square_char(input logic [7:0] d);
    case (d)
      8'd11: square_char = "D";  8'd12: square_char = "A";  8'd13: square_char = "N";  8'd14: square_char = "I";  8'd15: square_char = "E";
      8'd21: square_char = "L";  8'd22: square_char = "B";  8'd23: square_char = "C";  8'd24: square_char = "F";  8'd25: square_char = "G";
      8'd31: square_char = "H";  8'd32: square_char = "K";  8'd33: square_char = "M";  8'd34: square_char = "O";  8'd35: square_char = "P";
      8'd41: square_char = "Q";  8'd42: square_char = "R";  8'd43: square_char = "S";  8'd44: square_char = "T";  8'd45: square_char = "U";
      8'd51: square_char = "V";  8'd52: square_char = "W";  8'd53: square_char = "X";  8'd54: square_char = "Y";  8'd55: square_char = "Z";
      default: square_char = 8'd0;
    endcase
  endfunction

  always_ff @(posedge i_w_clk or posedge i_w_rst) begin
    if (i_w_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_w_start) state_d = ST_RUN;
      ST_RUN:   if (accept_c && strm_io.i_w_last) state_d = ST_DRAIN;
      ST_DRAIN: if (out_take_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Single output register: RUN accepts whenever the held byte is empty or leaving.
  always_comb begin
    ready_c = 1'b0;
    if (state_q == ST_RUN) ready_c = !valid_q || strm_io.i_w_ready;
  end

  assign accept_c   = strm_io.i_w_valid && ready_c;
  assign out_take_c = valid_q && strm_io.i_w_ready;

  // Key letter 0 sits in the most-significant byte of the secret.
  always_comb begin
    key_c = '0;
    for (int unsigned i = 0; i < p_secret_length; i++) begin
      if (j_q == J_W'(i)) key_c = secret_q[(p_secret_length-1-i)*8 +: 8];
    end
  end

  assign pos_c  = key_pos(key_c);
  assign diff_c = strm_io.i_w_data - pos_c;
  assign char_c = square_char(diff_c);

  always_comb begin
    secret_d = secret_q;
    j_d      = j_q;
    count_d  = count_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    err_d    = err_q;
    if (state_q == ST_IDLE && i_w_start) begin
      secret_d = i_w_secret;
      j_d      = '0;
      count_d  = '0;
    end
    if (out_take_c) valid_d = 1'b0;
    if (accept_c) begin
      data_d  = (char_c != 8'd0) ? char_c : diff_c;
      err_d   = (pos_c == 8'd0);
      last_d  = strm_io.i_w_last;
      valid_d = 1'b1;
      count_d = count_q + 8'd1;
      j_d     = (j_q == J_W'(p_secret_length-1)) ? '0 : j_q + J_W'(1);
    end
  end

  always_ff @(posedge i_w_clk or posedge i_w_rst) begin
    if (i_w_rst) begin
      secret_q <= '0;
      j_q      <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      secret_q <= secret_d;
      j_q      <= j_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign strm_io.o_r_ready   = ready_c;
  assign strm_io.o_r_valid   = valid_q;
  assign strm_io.o_r_data    = data_q;
  assign strm_io.o_r_last    = last_q;
  assign strm_io.o_r_key_err = err_q;
  assign o_r_count           = count_q;
endmodule

// File: tb/tb_nihilist_stream_decrypt.sv
// Randomised self-checking bench for nihilist_stream_decrypt against a square-lookup model.
module tb_nihilist_stream_decrypt;
  logic        clk;
  logic        rst;
  logic        start;
  logic [47:0] secret;
  logic [7:0]  count;

  nihilist_stream_decrypt_if bus();

  nihilist_stream_decrypt #(.p_secret_length(6)) dut (
    .i_w_clk   (clk),
    .i_w_rst   (rst),
    .i_w_start (start),
    .i_w_secret(secret),
    .strm_io   (bus),
    .o_r_count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  string sq_s = "DANIELBCFGHKMOPQRSTUVWXYZ";

  logic [7:0] in_q[$];
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  int         cyc_used;
  bit         timed_out;

  // ---------------- reference model ----------------
  function automatic int mpos(input logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (c >= 8'h61 && c <= 8'h7a) u = c - 8'd32;
    for (int i = 0; i < 25; i++)
      if (8'(sq_s[i]) == u) return (i / 5 + 1) * 10 + (i % 5) + 1;
    return 0;
  endfunction

  function automatic logic [7:0] mdec(input logic [7:0] c, input int p);
    logic [7:0] d;
    int di;
    d  = c - 8'(p);
    di = int'(d);
    if (di >= 11 && di <= 55 && (di % 10) >= 1 && (di % 10) <= 5)
      return 8'(sq_s[(di / 10 - 1) * 5 + (di % 10) - 1]);
    return d;
  endfunction

  function automatic logic [7:0] kbyte(input logic [47:0] k, input int idx);
    return k[(5 - idx) * 8 +: 8];
  endfunction

  // Expected {last, key_err, data} for every byte of in_q, key index starting at 0.
  task automatic build_exp(input logic [47:0] k);
    int p;
    exp_q.delete();
    for (int i = 0; i < in_q.size(); i++) begin
      p = mpos(kbyte(k, i % 6));
      exp_q.push_back({(i == in_q.size() - 1), (p == 0), mdec(in_q[i], p)});
    end
  endtask

  function automatic logic [47:0] rand_key();
    logic [47:0] k;
    int r;
    k = '0;
    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      k[i*8 +: 8] = 8'h41 + 8'($urandom_range(0, 25));
      else if (r < 8) k[i*8 +: 8] = 8'h61 + 8'($urandom_range(0, 25));
      else            k[i*8 +: 8] = 8'($urandom_range(0, 255));
    end
    return k;
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic do_start(input logic [47:0] k);
    @(negedge clk);
    secret = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Streams in_q (last on final byte) and records accepted outputs until nout are seen.
  task automatic stream_msg(input int nout, input int vpct, input int rpct);
    int idx;
    bit pres;
    idx = 0;
    pres = 1'b0;
    obs_q.delete();
    timed_out = 1'b0;
    cyc_used  = 0;
    while (obs_q.size() < nout) begin
      if (cyc_used >= 2000) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      cyc_used++;
      bus.i_w_ready = (int'($urandom_range(0, 99)) < rpct);
      if (!pres && idx < in_q.size() && int'($urandom_range(0, 99)) < vpct) pres = 1'b1;
      bus.i_w_valid = pres;
      bus.i_w_data  = pres ? in_q[idx] : 8'h00;
      bus.i_w_last  = pres && (idx == in_q.size() - 1);
      #1;
      if (bus.o_r_valid && bus.i_w_ready)
        obs_q.push_back({bus.o_r_last, bus.o_r_key_err, bus.o_r_data});
      if (pres && bus.o_r_ready) begin
        pres = 1'b0;
        idx++;
      end
    end
    @(negedge clk);
    bus.i_w_valid = 1'b0;
    bus.i_w_last  = 1'b0;
    bus.i_w_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.o_r_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_r_valid); end
    checks++; if (bus.o_r_data !== 8'h00)   begin failures++; $display("FAIL reset_data got=%h exp=00", bus.o_r_data); end
    checks++; if (bus.o_r_last !== 1'b0)    begin failures++; $display("FAIL reset_last got=%b exp=0", bus.o_r_last); end
    checks++; if (bus.o_r_key_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.o_r_key_err); end
    checks++; if (count !== 8'h00)          begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    @(negedge clk);
    rst = 1'b0;
    bus.i_w_valid = 1'b1;
    bus.i_w_data  = 8'd45;
    #1;
    checks++; if (bus.o_r_ready !== 1'b0)   begin failures++; $display("FAIL idle_ready got=%b exp=0", bus.o_r_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.o_r_valid !== 1'b0)   begin failures++; $display("FAIL idle_no_accept got=%b exp=0", bus.o_r_valid); end
    bus.i_w_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_start("DADADA");
    in_q = '{8'd45, 8'd36, 8'd36};
    build_exp("DADADA");
    stream_msg(3, 100, 100);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_out[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (cyc_used !== 4)         begin failures++; $display("FAIL basic_latency got=%0d exp=4", cyc_used); end
    #1;
    checks++; if (count !== 8'd3)         begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
    checks++; if (bus.o_r_valid !== 1'b0) begin failures++; $display("FAIL basic_idle_valid got=%b exp=0", bus.o_r_valid); end
    checks++; if (bus.o_r_ready !== 1'b0) begin failures++; $display("FAIL basic_idle_ready got=%b exp=0", bus.o_r_ready); end
  endtask

  task automatic test_passthrough();
    do_start("DDDDDD");
    in_q = '{8'd57, 8'd43, 8'd11, 8'd255};
    build_exp("DDDDDD");
    stream_msg(4, 100, 100);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL pass_timeout got=%b exp=0", timed_out); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL pass_out[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bad_key();
    do_start("JjJ#J ");
    in_q = '{8'd34};
    for (int i = 0; i < 5; i++) in_q.push_back(8'($urandom_range(0, 255)));
    build_exp("JjJ#J ");
    stream_msg(6, 80, 80);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL badkey_timeout got=%b exp=0", timed_out); end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL badkey_out[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[$];
    logic [7:0] d0;
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom_range(0, 255)));
    in_q = b;
    build_exp("DADADA");
    do_start("DADADA");
    @(negedge clk);
    bus.i_w_ready = 1'b1;
    bus.i_w_valid = 1'b1;
    bus.i_w_data  = b[0];
    bus.i_w_last  = 1'b0;
    @(negedge clk);
    bus.i_w_ready = 1'b0;
    bus.i_w_data  = b[1];
    #1;
    d0 = bus.o_r_data;
    checks++; if (bus.o_r_valid !== 1'b1)      begin failures++; $display("FAIL bp_first_valid got=%b exp=1", bus.o_r_valid); end
    checks++; if (d0 !== exp_q[0][7:0])        begin failures++; $display("FAIL bp_first_data got=%h exp=%h", d0, exp_q[0][7:0]); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++; if (bus.o_r_ready !== 1'b0)    begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", c, bus.o_r_ready); end
      checks++; if (bus.o_r_valid !== 1'b1 || bus.o_r_data !== d0)
        begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", c, bus.o_r_valid, bus.o_r_data, d0); end
      checks++; if (count !== 8'd1)            begin failures++; $display("FAIL bp_count[%0d] got=%0d exp=1", c, count); end
    end
    in_q.delete();
    for (int i = 1; i < 6; i++) in_q.push_back(b[i]);
    stream_msg(6, 100, 100);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%b exp=0", timed_out); end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_out[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (cyc_used !== 6) begin failures++; $display("FAIL bp_throughput got=%0d exp=6", cyc_used); end
  endtask

  task automatic test_key_wrap();
    do_start("DANIEL");
    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(8'($urandom_range(0, 255)));
    build_exp("DANIEL");
    stream_msg(8, 70, 70);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL wrap_timeout got=%b exp=0", timed_out); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_out[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (count !== 8'd8) begin failures++; $display("FAIL wrap_count got=%0d exp=8", count); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b[$];
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom_range(0, 255)));
    do_start("DANIEL");
    @(negedge clk);
    bus.i_w_ready = 1'b1;
    bus.i_w_valid = 1'b1;
    bus.i_w_data  = b[0];
    @(negedge clk);
    bus.i_w_data  = b[1];
    @(negedge clk);
    bus.i_w_data  = b[2];
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.o_r_valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%b exp=0", bus.o_r_valid); end
    checks++; if (count !== 8'd0)         begin failures++; $display("FAIL mr_count got=%0d exp=0", count); end
    checks++; if (bus.o_r_ready !== 1'b0) begin failures++; $display("FAIL mr_ready got=%b exp=0", bus.o_r_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.o_r_valid !== 1'b0 || count !== 8'd0)
      begin failures++; $display("FAIL mr_quiet got=%b/%0d exp=0/0", bus.o_r_valid, count); end
    bus.i_w_valid = 1'b0;
    bus.i_w_ready = 1'b0;
    do_start("DANIEL");
    in_q = b;
    build_exp("DANIEL");
    stream_msg(4, 80, 80);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL mr_timeout got=%b exp=0", timed_out); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL mr_out[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [47:0] k;
    int n;
    for (int m = 0; m < 6; m++) begin
      k = rand_key();
      n = int'($urandom_range(1, 24));
      in_q.delete();
      for (int i = 0; i < n; i++) in_q.push_back(8'($urandom_range(0, 255)));
      build_exp(k);
      do_start(k);
      stream_msg(n, int'($urandom_range(40, 100)), int'($urandom_range(40, 100)));
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rnd%0d_timeout got=%b exp=0", m, timed_out); end
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_out[%0d] got=%h exp=%h key=%h", m, i, obs_q[i], exp_q[i], k); end
      end
      checks++; if (count !== 8'(n)) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", m, count, n); end
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    secret        = '0;
    bus.i_w_valid = 1'b0;
    bus.i_w_data  = 8'h00;
    bus.i_w_last  = 1'b0;
    bus.i_w_ready = 1'b0;
    test_reset();
    test_basic();
    test_passthrough();
    test_bad_key();
    test_backpressure();
    test_key_wrap();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
